spi_reg_peripheral: RTL

- Parametrised successor to the single-byte SPI peripheral.
- SPI mode 0 slave, oversampled in the m_clk domain, with a framed command protocol.
- Each frame carries one command byte followed by a burst of data bytes that read or write a local register bank.
- reg_out drives LEDs and GPIO at the top level.

---
 rtl/spi_reg_peripheral.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/spi_reg_peripheral.sv
// rtl/spi_reg_peripheral.sv - SPI mode 0 slave with framed command access to a local register bank
// Optional macro SPI_AUTOINC_EN: post-increment the register address after every data byte.
module spi_reg_peripheral #(
  parameter int BYTE_W      = 8,
  parameter int ADDR_W      = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic                           m_clk,
  input  logic                           rst_n,
  input  logic                           sck_pad,
  input  logic                           csn_pad,
  input  logic                           mosi_pad,
  output logic                           miso_pad,
  output logic                           miso_oe,
  output logic [(2**ADDR_W)*BYTE_W-1:0]  reg_out,
  output logic                           wr_strobe,
  output logic [ADDR_W-1:0]              wr_addr,
  output logic                           frame_done
);
  localparam int NUM_REGS = 2**ADDR_W;
  localparam int CNT_W    = $clog2(BYTE_W);
  localparam int S        = SYNC_STAGES;

  typedef enum logic [2:0] {IDLE, CMD, DATA_WR, DATA_RD, ERR} state_t;

  logic [S-1:0]        sck_sync, csn_sync, mosi_sync, sync_fill;
  logic                sck_rise, sck_fall, csn_rise, csn_fall, mosi_s;
  state_t              state, state_eff;
  logic                armed, err_sticky, byte_done, cmd_bad, active;
  logic [CNT_W-1:0]    bit_cnt, cnt_inc, cnt_eff;
  logic [BYTE_W-2:0]   rx_shift, frame_cnt;
  logic [BYTE_W-1:0]   rx_next, tx_shift, status;
  logic [ADDR_W-1:0]   addr;
  logic [BYTE_W-1:0]   regs [NUM_REGS];

  // sync_fill marks when every synchroniser stage holds a real pad sample rather than a reset value
  always_ff @(posedge m_clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_sync  <= '0;
      csn_sync  <= '1;
      mosi_sync <= '0;
      sync_fill <= '0;
    end else begin
      sck_sync  <= {sck_sync[S-2:0], sck_pad};
      csn_sync  <= {csn_sync[S-2:0], csn_pad};
      mosi_sync <= {mosi_sync[S-2:0], mosi_pad};
      sync_fill <= {sync_fill[S-2:0], 1'b1};
    end
  end

  assign sck_rise = sck_sync[S-2] & ~sck_sync[S-1];
  assign sck_fall = ~sck_sync[S-2] & sck_sync[S-1];
  assign csn_rise = csn_sync[S-2] & ~csn_sync[S-1];
  assign csn_fall = ~csn_sync[S-2] & csn_sync[S-1];
  assign mosi_s   = mosi_sync[S-1];

  // cnt_eff/state_eff reflect this cycle's SCK rise so a simultaneous CSN rise sees the completed byte
  always_comb begin
    rx_next   = {rx_shift, mosi_s};
    status    = {err_sticky, frame_cnt};
    cnt_inc   = (bit_cnt == CNT_W'(BYTE_W-1)) ? '0 : bit_cnt + 1'b1;
    active    = (state == CMD) || (state == DATA_WR) || (state == DATA_RD);
    byte_done = active && sck_rise && (bit_cnt == CNT_W'(BYTE_W-1));
    cmd_bad   = |(rx_next[BYTE_W-2:0] >> ADDR_W);
    cnt_eff   = (active && sck_rise) ? cnt_inc : bit_cnt;
    state_eff = state;
    if (byte_done && state == CMD)
      state_eff = cmd_bad ? ERR : (rx_next[BYTE_W-1] ? DATA_RD : DATA_WR);
  end

  always_ff @(posedge m_clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      armed      <= 1'b0;
      bit_cnt    <= '0;
      rx_shift   <= '0;
      tx_shift   <= '0;
      addr       <= '0;
      frame_cnt  <= '0;
      err_sticky <= 1'b0;
      miso_pad   <= 1'b0;
      miso_oe    <= 1'b0;
      wr_strobe  <= 1'b0;
      wr_addr    <= '0;
      frame_done <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      wr_strobe  <= 1'b0;
      frame_done <= 1'b0;
      if (sync_fill[S-1] && csn_sync[S-1]) armed <= 1'b1;
      if (state == IDLE) begin
        if (csn_fall && armed) begin
          state      <= CMD;
          bit_cnt    <= '0;
          miso_oe    <= 1'b1;
          tx_shift   <= status;
          miso_pad   <= status[BYTE_W-1];
          err_sticky <= 1'b0;
        end
      end else begin
        if (active && sck_rise) begin
          rx_shift <= rx_next[BYTE_W-2:0];
          bit_cnt  <= cnt_inc;
          state    <= state_eff;
          if (byte_done && state == CMD) begin
            addr <= rx_next[ADDR_W-1:0];
            if (cmd_bad) err_sticky <= 1'b1;
          end else if (byte_done && state == DATA_WR) begin
            regs[addr] <= rx_next;
            wr_strobe  <= 1'b1;
            wr_addr    <= addr;
`ifdef SPI_AUTOINC_EN
            addr <= addr + 1'b1;
`endif
          end
        end
        if (active && sck_fall) begin
          if (bit_cnt != '0) begin
            tx_shift <= tx_shift << 1;
            miso_pad <= tx_shift[BYTE_W-2];
          end else if (state == DATA_RD) begin
            tx_shift <= regs[addr];
            miso_pad <= regs[addr][BYTE_W-1];
`ifdef SPI_AUTOINC_EN
            addr <= addr + 1'b1;
`endif
          end else begin
            tx_shift <= '0;
            miso_pad <= 1'b0;
          end
        end
        if (state == ERR) miso_pad <= 1'b0;
        if (csn_rise) begin
          state    <= IDLE;
          miso_oe  <= 1'b0;
          miso_pad <= 1'b0;
          bit_cnt  <= '0;
          if (cnt_eff != '0) begin
            err_sticky <= 1'b1;
          end else if (state_eff == DATA_WR || state_eff == DATA_RD) begin
            frame_done <= 1'b1;
            frame_cnt  <= frame_cnt + 1'b1;
          end
        end
      end
    end
  end

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg_out
    assign reg_out[i*BYTE_W +: BYTE_W] = regs[i];
  end

endmodule
